// File: rtl/dmem_resp.sv
// dmem_resp: data memory with asynchronous read, a one-entry store write
// buffer and store-to-load byte forwarding. Datapath is organised as four
// byte lanes, so XLEN is expected to be 32.
// Optional build macro DMEM_MISALIGN_CHK_EN enables misalignment/size
// checking with a registered error pulse and captured fault address.
module dmem_resp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            adr_v_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      access_size_i,
  output logic [XLEN-1:0] load_data_o,
  output logic            wb_pending_o,
  output logic            err_v_q_o,
  output logic [XLEN-1:0] err_adr_q_o
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned NLANES = 4;

  logic [XLEN-1:0]   mem [DEPTH];

  logic              wb_valid;
  logic [IDX_W-1:0]  wb_idx;
  logic [NLANES-1:0] wb_be;
  logic [XLEN-1:0]   wb_data;

  logic              is_byte_c;
  logic              is_half_c;
  logic              fault_c;
  logic              st_accept_c;
  logic              ld_c;
  logic [IDX_W-1:0]  req_idx_c;
  logic [NLANES-1:0] be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   rd_word_c;

  assign req_idx_c = adr_i[2 +: IDX_W];
  assign is_byte_c = (access_size_i == 3'b001);
  assign is_half_c = (access_size_i == 3'b010);

`ifdef DMEM_MISALIGN_CHK_EN
  logic is_word_c;
  assign is_word_c = (access_size_i == 3'b100);
  // A request faults on a misaligned half/word or a size that is not one-hot
  assign fault_c = adr_v_i & ((is_half_c & adr_i[0]) |
                              (is_word_c & (adr_i[1:0] != 2'b00)) |
                              ~(is_byte_c | is_half_c | is_word_c));
`else
  // No checking: anything that is not byte or half behaves as a word
  assign fault_c = 1'b0;
  logic unused_adr_c;
  assign unused_adr_c = &{1'b0, adr_i[XLEN-1:IDX_W+2]};
`endif

  assign st_accept_c = adr_v_i & is_store_i & ~fault_c;
  assign ld_c        = adr_v_i & ~is_store_i & ~fault_c;

  // Byte enables and lane placement of store data
  always_comb begin
    be_c    = '0;
    wdata_c = store_data_i;
    if (is_byte_c) begin
      be_c[adr_i[1:0]] = 1'b1;
      wdata_c          = XLEN'({4{store_data_i[7:0]}});
    end else if (is_half_c) begin
      be_c    = adr_i[1] ? 4'b1100 : 4'b0011;
      wdata_c = XLEN'({2{store_data_i[15:0]}});
    end else begin
      be_c = 4'b1111;
    end
  end

  // Write buffer: capture an accepted store; an entry lives exactly one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_idx   <= '0;
      wb_be    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= st_accept_c;
      if (st_accept_c) begin
        wb_idx  <= req_idx_c;
        wb_be   <= be_c;
        wb_data <= wdata_c;
      end
    end
  end

  // Array commit of the buffered entry; the array itself is never reset
  always_ff @(posedge clk) begin
    if (wb_valid) begin
      for (int unsigned l = 0; l < NLANES; l++) begin
        if (wb_be[l]) mem[wb_idx][8*l +: 8] <= wb_data[8*l +: 8];
      end
    end
  end

  // Asynchronous read with per-lane forwarding from a matching buffer entry
  always_comb begin
    rd_word_c = mem[req_idx_c];
    for (int unsigned l = 0; l < NLANES; l++) begin
      if (wb_valid && (wb_idx == req_idx_c) && wb_be[l]) begin
        rd_word_c[8*l +: 8] = wb_data[8*l +: 8];
      end
    end
    load_data_o = ld_c ? rd_word_c : '0;
  end

  assign wb_pending_o = wb_valid;

`ifdef DMEM_MISALIGN_CHK_EN
  // Error pulse for the cycle after a fault; address held until the next one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_v_q_o   <= 1'b0;
      err_adr_q_o <= '0;
    end else begin
      err_v_q_o <= fault_c;
      if (fault_c) err_adr_q_o <= adr_i;
    end
  end
`else
  assign err_v_q_o   = 1'b0;
  assign err_adr_q_o = '0;
`endif

endmodule
